// File: rtl/music_scheduler.sv
// music_scheduler: round-robin sequencer enabling one song player at a time, with silent gaps and a registered buzzer mux
module music_scheduler #(
    parameter int GAP_CYCLES = 25_000_000
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic [2:0] req_msc,
    input  logic       stop,
    input  logic [2:0] done_msc,
    input  logic [2:0] buzzer_msc,
    output logic [2:0] play_msc,
    output logic       buzzer_para_placa,
    output logic [2:0] pending_msc,
    output logic [1:0] song_atual,
    output logic       busy
);
    localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
    state_t state, state_nxt;
    logic [2:0] pending, pending_nxt, play_oh, grant_oh;
    logic [1:0] sel, sel_nxt, last, last_nxt, c1, c2, cand;
    logic [CW-1:0] cnt, cnt_nxt;
    logic grant, buz;

    // round-robin pick, next state; the last gap cycle grants directly so a new song starts GAP_CYCLES+1 after done
    always_comb begin
        play_oh = (state == PLAY) ? 3'b001 << sel : 3'b000;
        c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        cand = pending[c1] ? c1 : (pending[c2] ? c2 : last);
        grant = !stop && (pending != 3'b000) && ((state == IDLE) || (state == GAP && cnt == '0));
        grant_oh = grant ? 3'b001 << cand : 3'b000;
        state_nxt = state;
        sel_nxt = sel;
        last_nxt = last;
        cnt_nxt = cnt;
        case (state)
            PLAY: if (stop || done_msc[sel]) begin
                state_nxt = GAP;
                cnt_nxt = CW'(GAP_CYCLES);
            end
            GAP: if (cnt == '0) state_nxt = IDLE;
                 else cnt_nxt = cnt - CW'(1);
            default: state_nxt = IDLE;
        endcase
        if (grant) begin
            state_nxt = PLAY;
            sel_nxt = cand;
            last_nxt = cand;
        end
        pending_nxt = stop ? 3'b000 : (pending | (req_msc & ~play_oh)) & ~grant_oh;
    end

    // state, queue, selection and registered buzzer drive
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= IDLE;
            pending <= 3'b000;
            sel <= 2'd0;
            last <= 2'd2;
            cnt <= '0;
            buz <= 1'b0;
        end else begin
            state <= state_nxt;
            pending <= pending_nxt;
            sel <= sel_nxt;
            last <= last_nxt;
            cnt <= cnt_nxt;
            buz <= (state == PLAY) & buzzer_msc[sel];
        end
    end

    assign play_msc = play_oh;
    assign buzzer_para_placa = buz;
    assign pending_msc = pending;
    assign song_atual = (state == PLAY) ? sel + 2'd1 : 2'd0;
    assign busy = (state != IDLE);
endmodule

// File: tb/tb_music_scheduler.sv
// tb_music_scheduler: directed scenarios plus randomized traffic checked against a queue/song reference model
module tb_music_scheduler;
    localparam int G = 4;
    logic clock_in = 1'b0, reset = 1'b1, stop = 1'b0;
    logic [2:0] req_msc = '0, done_msc = '0, buzzer_msc = '0;
    logic [2:0] play_msc, pending_msc;
    logic [1:0] song_atual;
    logic buzzer_para_placa, busy;
    int tests = 0, fails = 0;

    // reference model: song number playing, gap cycles left (-1 when not in a gap), queued songs, last granted index
    int m_song = 0, m_gap = -1, m_last = 2;
    logic [2:0] m_pend = '0;
    logic m_buz = 1'b0;

    music_scheduler #(.GAP_CYCLES(G)) dut (
        .clock_in(clock_in), .reset(reset), .req_msc(req_msc), .stop(stop),
        .done_msc(done_msc), .buzzer_msc(buzzer_msc), .play_msc(play_msc),
        .buzzer_para_placa(buzzer_para_placa), .pending_msc(pending_msc),
        .song_atual(song_atual), .busy(busy)
    );

    always #5 clock_in = ~clock_in;

    // model update from the song-level rules, sampled at the same edge as the DUT
    always @(posedge clock_in) begin : model
        int n_song, n_gap, g;
        logic [2:0] n_pend;
        if (reset) begin
            m_song <= 0; m_gap <= -1; m_pend <= '0; m_last <= 2; m_buz <= 1'b0;
        end else begin
            n_pend = m_pend | req_msc;
            if (m_song != 0) n_pend[m_song-1] = m_pend[m_song-1];
            n_song = m_song;
            n_gap = m_gap;
            g = -1;
            if (m_song != 0) begin
                if (stop || done_msc[m_song-1]) begin n_song = 0; n_gap = G; end
            end else if (m_gap > 0) begin
                n_gap = m_gap - 1;
            end else begin
                n_gap = -1;
                if (!stop)
                    for (int k = 1; k <= 3; k++)
                        if (g < 0 && m_pend[(m_last + k) % 3]) g = (m_last + k) % 3;
                if (g >= 0) begin n_song = g + 1; n_pend[g] = 1'b0; m_last <= g; end
            end
            if (stop) n_pend = '0;
            m_buz <= (m_song != 0) ? buzzer_msc[m_song-1] : 1'b0;
            m_song <= n_song; m_gap <= n_gap; m_pend <= n_pend;
        end
    end

    task automatic cyc();
        @(negedge clock_in);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_msc = '0; done_msc = '0; stop = 1'b0; buzzer_msc = '0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_req(input logic [2:0] r);
        req_msc = r; cyc(); req_msc = '0;
    endtask

    task automatic pulse_done(input logic [2:0] d);
        done_msc = d; cyc(); done_msc = '0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (play_msc !== 3'b000) begin fails++; $display("FAIL reset_play got %b want 000", play_msc); end
        tests++; if (pending_msc !== 3'b000) begin fails++; $display("FAIL reset_pending got %b want 000", pending_msc); end
        tests++; if (song_atual !== 2'd0) begin fails++; $display("FAIL reset_song got %0d want 0", song_atual); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (buzzer_para_placa !== 1'b0) begin fails++; $display("FAIL reset_buzzer got %b want 0", buzzer_para_placa); end
    endtask

    task automatic test_single_song();
        int n;
        do_reset();
        pulse_req(3'b001);
        tests++; if (pending_msc !== 3'b001 || play_msc !== 3'b000) begin fails++; $display("FAIL single_latch got pend=%b play=%b want 001/000", pending_msc, play_msc); end
        cyc();
        tests++; if (play_msc !== 3'b001 || song_atual !== 2'd1 || pending_msc !== 3'b000) begin fails++; $display("FAIL single_grant got play=%b song=%0d pend=%b want 001/1/000", play_msc, song_atual, pending_msc); end
        buzzer_msc = 3'b010; cyc();
        tests++; if (buzzer_para_placa !== 1'b0) begin fails++; $display("FAIL single_mask got %b want 0", buzzer_para_placa); end
        buzzer_msc = 3'b001; cyc();
        tests++; if (buzzer_para_placa !== 1'b1) begin fails++; $display("FAIL single_buz_on got %b want 1", buzzer_para_placa); end
        buzzer_msc = 3'b010; cyc();
        tests++; if (buzzer_para_placa !== 1'b0) begin fails++; $display("FAIL single_buz_off got %b want 0", buzzer_para_placa); end
        buzzer_msc = 3'b000;
        pulse_done(3'b001);
        tests++; if (play_msc !== 3'b000 || busy !== 1'b1) begin fails++; $display("FAIL single_done got play=%b busy=%b want 000/1", play_msc, busy); end
        n = 0;
        while (busy && n < 20) begin cyc(); n++; end
        tests++; if (n != G + 1) begin fails++; $display("FAIL single_gap_len got %0d want %0d", n, G + 1); end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        pulse_req(3'b001); cyc();
        pulse_req(3'b100); pulse_req(3'b010);
        tests++; if (pending_msc !== 3'b110) begin fails++; $display("FAIL rr_pending got %b want 110", pending_msc); end
        pulse_done(3'b001);
        n = 0;
        while (play_msc == 3'b000 && n < 20) begin cyc(); n++; end
        tests++; if (n != G + 1 || play_msc !== 3'b010 || pending_msc !== 3'b100) begin fails++; $display("FAIL rr_second got gap=%0d play=%b pend=%b want %0d/010/100", n, play_msc, pending_msc, G + 1); end
        pulse_done(3'b010);
        n = 0;
        while (play_msc == 3'b000 && n < 20) begin cyc(); n++; end
        tests++; if (n != G + 1 || play_msc !== 3'b100 || pending_msc !== 3'b000) begin fails++; $display("FAIL rr_third got gap=%0d play=%b pend=%b want %0d/100/000", n, play_msc, pending_msc, G + 1); end
        pulse_done(3'b100);
        repeat (G + 2) cyc();
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        pulse_req(3'b111);
        tests++; if (pending_msc !== 3'b111) begin fails++; $display("FAIL sim_latch got %b want 111", pending_msc); end
        cyc();
        tests++; if (play_msc !== 3'b001 || pending_msc !== 3'b110) begin fails++; $display("FAIL sim_first got play=%b pend=%b want 001/110", play_msc, pending_msc); end
        for (int s = 1; s < 3; s++) begin
            pulse_done(play_msc);
            n = 0;
            while (play_msc == 3'b000 && n < 20) begin cyc(); n++; end
            tests++; if (song_atual !== 2'(s + 1) || pending_msc !== ((s == 1) ? 3'b100 : 3'b000)) begin fails++; $display("FAIL sim_order got song=%0d pend=%b want %0d", song_atual, pending_msc, s + 1); end
        end
        pulse_done(3'b100);
        repeat (G + 2) cyc();
    endtask

    task automatic test_stop_queue();
        int n;
        logic saw_play;
        do_reset();
        pulse_req(3'b010); cyc();
        pulse_req(3'b101);
        tests++; if (play_msc !== 3'b010 || pending_msc !== 3'b101) begin fails++; $display("FAIL stop_setup got play=%b pend=%b want 010/101", play_msc, pending_msc); end
        stop = 1'b1; done_msc = 3'b010; req_msc = 3'b001; cyc();
        stop = 1'b0; done_msc = '0; req_msc = '0;
        tests++; if (play_msc !== 3'b000 || busy !== 1'b1 || pending_msc !== 3'b000) begin fails++; $display("FAIL stop_abort got play=%b busy=%b pend=%b want 000/1/000", play_msc, busy, pending_msc); end
        n = 0; saw_play = 1'b0;
        while (busy && n < 20) begin cyc(); n++; saw_play |= |play_msc; end
        cyc(); saw_play |= |play_msc;
        tests++; if (n != G + 1 || saw_play) begin fails++; $display("FAIL stop_idle got gap=%0d played=%b want %0d/0", n, saw_play, G + 1); end
    endtask

    task automatic test_ignored();
        do_reset();
        pulse_req(3'b100); cyc();
        req_msc = 3'b100; done_msc = 3'b001; cyc();
        req_msc = '0; done_msc = '0;
        tests++; if (pending_msc !== 3'b000 || play_msc !== 3'b100 || song_atual !== 2'd3) begin fails++; $display("FAIL ignored got pend=%b play=%b song=%0d want 000/100/3", pending_msc, play_msc, song_atual); end
        cyc();
        tests++; if (play_msc !== 3'b100) begin fails++; $display("FAIL ignored_keep got %b want 100", play_msc); end
        pulse_done(3'b100);
        repeat (G + 2) cyc();
    endtask

    task automatic test_mid_reset();
        do_reset();
        pulse_req(3'b001); cyc();
        buzzer_msc = 3'b001; cyc();
        reset = 1'b1; cyc(); reset = 1'b0; buzzer_msc = '0;
        tests++; if (play_msc !== 3'b000 || busy !== 1'b0 || song_atual !== 2'd0 || buzzer_para_placa !== 1'b0 || pending_msc !== 3'b000) begin fails++; $display("FAIL midreset got play=%b busy=%b song=%0d buz=%b pend=%b want all 0", play_msc, busy, song_atual, buzzer_para_placa, pending_msc); end
        pulse_req(3'b010); cyc();
        tests++; if (play_msc !== 3'b010) begin fails++; $display("FAIL midreset_grant got %b want 010", play_msc); end
    endtask

    task automatic test_random();
        logic [2:0] e_play;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            e_play = (m_song != 0) ? 3'(1 << (m_song - 1)) : 3'b000;
            tests++;
            if (play_msc !== e_play || song_atual !== 2'(m_song) || pending_msc !== m_pend ||
                busy !== (m_song != 0 || m_gap >= 0) || buzzer_para_placa !== m_buz) begin
                fails++;
                $display("FAIL rand_%0d got play=%b song=%0d pend=%b busy=%b buz=%b want %b/%0d/%b/%b/%b", i,
                         play_msc, song_atual, pending_msc, busy, buzzer_para_placa,
                         e_play, m_song, m_pend, (m_song != 0 || m_gap >= 0), m_buz);
            end
            req_msc = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            done_msc = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
            stop = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 299) == 0);
            buzzer_msc = 3'($urandom);
            cyc();
        end
        reset = 1'b0; req_msc = '0; done_msc = '0; stop = 1'b0; buzzer_msc = '0;
    endtask

    initial begin
        test_reset();
        test_single_song();
        test_round_robin();
        test_simultaneous();
        test_stop_queue();
        test_ignored();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/music_scheduler.md
# music_scheduler

Sequences the three song-player blocks so that exactly one plays at a time, and drives the board buzzer from the active player only. It sits between the debounced song-select buttons and the three player blocks, and replaces the OR-merge of their buzzer outputs. Song requests are latched and served round-robin. A fixed silent gap separates consecutive songs. A stop input aborts the current song and discards all queued requests.

## Interface
- GAP_CYCLES, default 25_000_000: silent cycles between songs (0.5 s at 50 MHz); 0 is legal.
- clock_in  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- req_msc  input  3  request pulses (bit i = song i+1), one cycle wide, already debounced.
- stop  input  1  abort the current song and clear the queue; level-sampled.
- done_msc  input  3  end-of-song flag from each player (pulse or level).
- buzzer_msc  input  3  buzzer output of each player.
- play_msc  output  3  one-hot enable to the players; all zero when nothing plays.
- buzzer_para_placa  output  1  registered buzzer drive to the board.
- pending_msc  output  3  queued requests, for LEDs.
- song_atual  output  2  0 = none, 1..3 = song currently enabled.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, PLAY, GAP. Registers: state, pending[2:0], sel[1:0], last[1:0], gap counter (width = clog2(GAP_CYCLES+1), minimum 1).
- Request latch (every cycle, any state):
  - pending[i] <= 1 when req_msc[i]=1.
  - A request for the song currently in PLAY is ignored.
- IDLE:
  - If pending != 0, grant the first set bit searching round-robin from last+1 (wrapping 2→0).
  - On grant: sel = that index, last = that index, pending[sel] cleared, state goes to PLAY.
  - If pending = 0, stay in IDLE.
- PLAY:
  - play_msc = one-hot(sel).
  - buzzer_para_placa <= buzzer_msc[sel]; all other buzzer inputs are masked.
  - done_msc[sel]=1 → GAP. done_msc on any other index is ignored.
  - stop=1 → GAP, and pending is cleared in the same edge.
  - stop takes precedence over done and over requests arriving in the same cycle: the queue ends up empty.
- GAP:
  - play_msc = 0 and buzzer_para_placa = 0.
  - The counter is loaded with GAP_CYCLES on entry and decrements each cycle; the state goes to IDLE when the counter reaches 0.
  - GAP_CYCLES=0 means GAP lasts exactly 1 cycle.
  - stop in GAP clears pending.
  - Requests received during GAP are queued.
- song_atual = sel+1 in PLAY, otherwise 0. busy = (state != IDLE).
- Reset:
  - state = IDLE; pending = 0; sel = 0; last = 2, so the first grant priority is song 1.
  - Counter cleared; all outputs 0.
  - Reset mid-song drops play_msc the following cycle; players see an enable falling edge and must restart.

## Timing
- A request sampled at edge k sets pending at k. If in IDLE, the grant happens at edge k+1, so play_msc is high from k+1.
  - The request-to-enable latency is therefore 2 cycles.
  - pending_msc shows the bit for 1 cycle before it clears.
- buzzer_para_placa lags buzzer_msc[sel] by 1 cycle. It is forced to 0 starting the cycle after PLAY is left.
- done sampled at edge d → play_msc low from d. The next grant happens at edge d+GAP_CYCLES+1, so the earliest new enable is GAP_CYCLES+1 cycles after done.
- play_msc never has more than one bit set, and never changes index without passing through GAP.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan (GAP_CYCLES=4)
- **Reset and single song:** reset, then req_msc=001 → play_msc=001 two cycles later; song_atual=1; toggle buzzer_msc[0] and buzzer_msc[1] → only the bit-0 toggles appear on buzzer_para_placa, 1 cycle late; done_msc[0] → play_msc=000, then IDLE after 5 cycles, busy=0.
- **Round-robin:** while song 1 plays, pulse req 100 then 010 → pending=110; songs are served in the order 2 then 3 (last=0), each preceded by a 5-cycle gap.
- **Simultaneous requests from reset:** req_msc=111 in one cycle → order 1, 2, 3; pending goes 111→110→100→000.
- **Stop with queue:** song 2 playing, pending=101, stop=1 with done_msc[1] and req_msc[0] in the same cycle → GAP, pending=000, returns to IDLE with no grant.
- **Ignored inputs:** while song 3 plays, pulse req_msc[2] and done_msc[0] → pending stays 000 and song 3 keeps playing.
- **Mid-song reset:** reset during PLAY → next cycle all outputs 0 and state IDLE; a later req 010 grants song 2 (last reset to 2 does not skip it).
